// File: rtl/maxpool_layer_sequencer.sv
// Layer sequencer: launches the maxpool engine once per batch and drains its result port onto a valid/ready stream.
// Optional WAIT-state watchdog is compiled in when MAXPOOL_SEQ_TIMEOUT_EN is defined.
module maxpool_layer_sequencer #(
  parameter int NUM_BATCHES    = 16,
  parameter int OUT_WORDS      = 3528,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int BATCH_W       = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  output logic               cmd_busy,
  output logic               cmd_done,
  output logic               cmd_error,
  output logic               eng_start,
  input  logic               eng_done,
  output logic [ADDR_W-1:0]  eng_read_addr,
  input  logic [DATA_W-1:0]  eng_read_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic [BATCH_W-1:0] m_batch
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, READ, NEXT} state_t;

  localparam logic [ADDR_W-1:0]  ADDR_END   = ADDR_W'(OUT_WORDS);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(OUT_WORDS - 1);
  localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(NUM_BATCHES - 1);

  state_t              state_reg, state_next;
  logic [BATCH_W-1:0]  batch_reg, batch_next;
  logic [ADDR_W-1:0]   addr_cnt_reg, addr_cnt_next;
  logic                armed_reg, armed_next;
  logic                done_reg, done_next;
  logic                eng_start_reg, busy_reg;
  logic                rd_pending_reg, rd_last_reg;
  logic                issue, push, pop, timeout;

  logic [DATA_W-1:0]   data_mem [4];
  logic                last_mem [4];
  logic [1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [2:0]          count_reg;

  assign push          = rd_pending_reg;
  assign pop           = m_valid & m_ready;
  assign m_valid       = (count_reg != 3'd0);
  assign m_data        = data_mem[rd_ptr_reg];
  assign m_last        = m_valid & last_mem[rd_ptr_reg];
  assign m_batch       = batch_reg;
  assign eng_read_addr = addr_cnt_reg;
  assign eng_start     = eng_start_reg;
  assign cmd_busy      = busy_reg;
  assign cmd_done      = done_reg;

  always_comb begin
    state_next    = state_reg;
    batch_next    = batch_reg;
    addr_cnt_next = addr_cnt_reg;
    armed_next    = armed_reg;
    done_next     = 1'b0;
    issue         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_start) begin
          state_next = LAUNCH;
          batch_next = '0;
        end
      end
      LAUNCH: begin
        armed_next = 1'b0;
        state_next = WAIT;
      end
      WAIT: begin
        // A done level still high from the previous batch is ignored until it has been seen low.
        if (!eng_done) armed_next = 1'b1;
        if (eng_done && armed_reg) begin
          state_next    = READ;
          addr_cnt_next = '0;
        end else if (timeout) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      READ: begin
        // Credit check keeps FIFO occupancy plus the read in flight at or below four.
        if (((count_reg + 3'(rd_pending_reg)) < 3'd4) && (addr_cnt_reg < ADDR_END)) begin
          issue         = 1'b1;
          addr_cnt_next = addr_cnt_reg + ADDR_W'(1);
        end
        if (pop && m_last) begin
          state_next = NEXT;
          done_next  = (batch_reg == BATCH_LAST);
        end
      end
      NEXT: begin
        if (batch_reg != BATCH_LAST) begin
          batch_next = batch_reg + BATCH_W'(1);
          state_next = LAUNCH;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (cmd_abort) begin
      state_next = IDLE;
      batch_next = batch_reg;
      done_next  = 1'b0;
      issue      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      batch_reg      <= '0;
      addr_cnt_reg   <= '0;
      armed_reg      <= 1'b0;
      done_reg       <= 1'b0;
      eng_start_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      rd_pending_reg <= 1'b0;
      rd_last_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      batch_reg      <= batch_next;
      addr_cnt_reg   <= addr_cnt_next;
      armed_reg      <= armed_next;
      done_reg       <= done_next;
      eng_start_reg  <= (state_next == LAUNCH);
      busy_reg       <= (state_next != IDLE);
      rd_pending_reg <= issue;
      rd_last_reg    <= (addr_cnt_reg == ADDR_LAST);
    end
  end

  // Four-entry output FIFO; abort drops both stored words and the read returning this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        data_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else if (cmd_abort) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push) begin
        data_mem[wr_ptr_reg] <= eng_read_data;
        last_mem[wr_ptr_reg] <= rd_last_reg;
        wr_ptr_reg           <= wr_ptr_reg + 2'd1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + 3'(push) - 3'(pop);
    end
  end

`ifdef MAXPOOL_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt_reg;
  logic            error_reg;

  assign timeout   = (state_reg == WAIT) && !(eng_done && armed_reg) &&
                     (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign cmd_error = error_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      if (state_reg != WAIT) wait_cnt_reg <= '0;
      else if (!timeout)     wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
      if (!cmd_abort) begin
        if ((state_reg == IDLE) && cmd_start) error_reg <= 1'b0;
        else if (timeout)                     error_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign cmd_error = 1'b0;

  // No watchdog in this build; the limit only takes part when the timer is compiled in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_maxpool_layer_sequencer.sv
// Directed bench for maxpool_layer_sequencer: small layer (2 batches x 8 words) against a behavioural engine model.
// Covers reset, full run, backpressure, stale done, abort, async reset and (with MAXPOOL_SEQ_TIMEOUT_EN) the watchdog.
module tb_maxpool_layer_sequencer;
  localparam int NB = 2;
  localparam int OW = 8;
  localparam int AW = 32;
  localparam int DW = 4;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_start = 1'b0, cmd_abort = 1'b0;
  logic          cmd_busy, cmd_done, cmd_error, eng_start;
  logic          eng_done = 1'b0;
  logic [AW-1:0] eng_read_addr;
  logic [DW-1:0] eng_read_data = '0;
  logic          m_valid, m_last, m_batch;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;

  maxpool_layer_sequencer #(
    .NUM_BATCHES(NB), .OUT_WORDS(OW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_error(cmd_error),
    .eng_start(eng_start), .eng_done(eng_done), .eng_read_addr(eng_read_addr),
    .eng_read_data(eng_read_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_batch(m_batch)
  );

  always #5 clk = ~clk;

  // Result words per address: -8, 7, -1, 0, 3, -5, 1, 6
  logic [3:0] rom [8] = '{4'h8, 4'h7, 4'hF, 4'h0, 4'h3, 4'hB, 4'h1, 4'h6};

  int vectors = 0, miscompares = 0;

  // Engine model: done rises 20 cycles after start; stale mode keeps the old done high 5 more cycles.
  // Reads taken before the real done return inverted data.
  logic stale_mode = 1'b0, hang_mode = 1'b0, eng_ok = 1'b0;
  int   hold_cnt = 0, run_cnt = 0;
  always @(posedge clk) begin
    if (eng_start) begin
      eng_ok   <= 1'b0;
      run_cnt  <= 20;
      hold_cnt <= stale_mode ? 5 : 0;
      if (!stale_mode) eng_done <= 1'b0;
    end else if (hang_mode) begin
      eng_done <= 1'b0;
    end else if (hold_cnt != 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) eng_done <= 1'b0;
    end else if (!eng_ok && run_cnt != 0) begin
      run_cnt <= run_cnt - 1;
      if (run_cnt == 1) begin
        eng_done <= 1'b1;
        eng_ok   <= 1'b1;
      end
    end
    eng_read_data <= (eng_read_addr < AW'(OW)) ?
                     (eng_ok ? rom[eng_read_addr[2:0]] : ~rom[eng_read_addr[2:0]]) : 4'h0;
  end

  // Stream monitor: records accepted beats and tallies protocol violations.
  logic [3:0] q_data[$];
  logic       q_last[$];
  logic       q_batch[$];
  int   starts = 0, dones = 0, stall_err = 0, out_err = 0, early_err = 0, accepted = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0, prev_batch = 1'b0;
  logic [3:0] prev_data = '0;
  always @(posedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
      accepted   <= 0;
    end else begin
      if (eng_start) starts <= starts + 1;
      if (cmd_done)  dones  <= dones + 1;
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        q_batch.push_back(m_batch);
      end
      if (prev_stall && !(m_valid && m_data === prev_data && m_last === prev_last && m_batch === prev_batch))
        stall_err <= stall_err + 1;
      prev_stall <= m_valid && !m_ready && !cmd_abort;
      prev_data  <= m_data;
      prev_last  <= m_last;
      prev_batch <= m_batch;
      if (eng_read_addr == '0) accepted <= 0;
      else if (m_valid && m_ready) accepted <= accepted + 1;
      if (eng_read_addr > AW'(accepted + 4)) out_err <= out_err + 1;
      if (m_valid && !eng_ok) early_err <= early_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) cmd_start = 1'b1;
    @(negedge clk) cmd_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit bp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cmd_done === 1'b1) ok = 1'b1;
      else if (bp) m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
  endtask

  task automatic check_layer(input string tag, input int base);
    chk({tag, "_beats"}, 32'(q_data.size() - base), 16);
    for (int k = 0; k < 16 && base + k < q_data.size(); k++) begin
      chk($sformatf("%s_data%0d", tag, k), q_data[base + k], rom[k % 8]);
      chk($sformatf("%s_last%0d", tag, k), q_last[base + k], (k % 8) == 7);
      chk($sformatf("%s_batch%0d", tag, k), q_batch[base + k], k / 8);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int base, s0, d0;

    // Reset values
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", cmd_busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_error", cmd_error, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_addr", eng_read_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_batch", m_batch, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full run, m_ready held high: latency, throughput, framing, single done
    base = q_data.size(); s0 = starts; d0 = dones;
    pulse_start();
    chk("t1_eng_start", eng_start, 1);
    chk("t1_busy", cmd_busy, 1);
    @(negedge clk);
    chk("t1_eng_start_pulse", eng_start, 0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (eng_done === 1'b1);
    end
    chk("t1_eng_done_seen", ok, 1);
    @(negedge clk);
    chk("t1_first_addr", eng_read_addr, 0);
    chk("t1_valid_w1", m_valid, 0);
    @(negedge clk);
    chk("t1_valid_w2", m_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t1_stream_valid%0d", i), m_valid, 1);
      chk($sformatf("t1_stream_last%0d", i), m_last, i == 7);
    end
    run_until_done(300, 1'b0, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_busy_at_done", cmd_busy, 1);
    @(negedge clk);
    chk("t1_busy_after", cmd_busy, 0);
    chk("t1_done_pulse", cmd_done, 0);
    chk("t1_starts", 32'(starts - s0), 2);
    chk("t1_dones", 32'(dones - d0), 1);
    check_layer("t1", base);

    // Backpressure plus a cmd_start issued while busy
    base = q_data.size(); s0 = starts; d0 = dones;
    pulse_start();
    repeat (3) @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk) cmd_start = 1'b0;
    run_until_done(2000, 1'b1, ok);
    chk("t2_done_seen", ok, 1);
    repeat (2) @(negedge clk);
    chk("t2_starts", 32'(starts - s0), 2);
    chk("t2_dones", 32'(dones - d0), 1);
    chk("t2_stall_stable", stall_err, 0);
    chk("t2_outstanding", out_err, 0);
    check_layer("t2", base);

    // Stale done carried across eng_start
    stale_mode = 1'b1;
    base = q_data.size(); s0 = starts;
    pulse_start();
    run_until_done(500, 1'b0, ok);
    chk("t3_done_seen", ok, 1);
    stale_mode = 1'b0;
    @(negedge clk);
    chk("t3_early_read", early_err, 0);
    chk("t3_starts", 32'(starts - s0), 2);
    check_layer("t3", base);

    // Abort while word 3 is presented, then abort+start together in IDLE, then restart
    base = q_data.size(); d0 = dones;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (q_data.size() - base == 3) && (m_valid === 1'b1);
    end
    chk("t4_word3_seen", ok, 1);
    chk("t4_word3_data", m_data, rom[3]);
    cmd_abort = 1'b1;
    @(negedge clk) cmd_abort = 1'b0;
    chk("t4_valid_drop", m_valid, 0);
    chk("t4_busy_drop", cmd_busy, 0);
    chk("t4_no_done", cmd_done, 0);
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    chk("t4_abort_wins_busy", cmd_busy, 0);
    chk("t4_abort_wins_start", eng_start, 0);
    chk("t4_no_done_count", 32'(dones - d0), 0);
    base = q_data.size(); s0 = starts;
    pulse_start();
    run_until_done(500, 1'b0, ok);
    chk("t4_restart_done", ok, 1);
    @(negedge clk);
    chk("t4_restart_starts", 32'(starts - s0), 2);
    check_layer("t4", base);

    // Async reset while batch 1 is streaming
    s0 = starts;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (m_valid === 1'b1) && (m_batch === 1'b1);
    end
    chk("t5_batch1_streaming", ok, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", cmd_busy, 0);
    chk("t5_valid", m_valid, 0);
    chk("t5_data", m_data, 0);
    chk("t5_batch", m_batch, 0);
    chk("t5_addr", eng_read_addr, 0);
    chk("t5_eng_start", eng_start, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle_busy", cmd_busy, 0);
    chk("t5_no_relaunch", 32'(starts - s0), 2);

`ifdef MAXPOOL_SEQ_TIMEOUT_EN
    // Watchdog: engine never finishes
    hang_mode = 1'b1;
    pulse_start();
    repeat (50) @(negedge clk);
    chk("t6_done_before", cmd_done, 0);
    chk("t6_busy_before", cmd_busy, 1);
    @(negedge clk);
    chk("t6_done", cmd_done, 1);
    chk("t6_error", cmd_error, 1);
    chk("t6_busy_after", cmd_busy, 0);
    @(negedge clk);
    chk("t6_done_pulse", cmd_done, 0);
    chk("t6_error_sticky", cmd_error, 1);
    pulse_start();
    chk("t6_error_cleared", cmd_error, 0);
    cmd_abort = 1'b1;
    @(negedge clk) cmd_abort = 1'b0;
    hang_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/maxpool_layer_sequencer.md
# maxpool_layer_sequencer

Sequencer that runs the 2x2/stride-2 maxpool engine over a whole layer of batches and streams its results out. For each batch it pulses the engine's start, waits for the engine's done, then sweeps the engine's result read port from address 0 to OUT_WORDS-1. Each result goes onto a valid/ready stream with per-batch framing. It sits between the layer-level control FSM and the maxpool engine, replacing testbench-style readout with a backpressure-aware drain.

## Interface

- NUM_BATCHES, 16, batches per layer command
- OUT_WORDS, 3528, result words read per batch (addresses 0..OUT_WORDS-1)
- ADDR_W, 32, engine read-address width
- DATA_W, 4, signed result width
- TIMEOUT_CYCLES, 1000000, watchdog limit in WAIT (used only with the macro)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_start  in  1  start layer; sampled only in IDLE
- cmd_abort  in  1  abort; highest priority
- cmd_busy  out  1  high whenever state != IDLE
- cmd_done  out  1  one-cycle pulse on layer completion or timeout
- cmd_error  out  1  sticky timeout flag; cleared by accepted cmd_start
- eng_start  out  1  one-cycle start pulse to engine
- eng_done  in  1  engine done, level
- eng_read_addr  out  ADDR_W  engine result address
- eng_read_data  in  DATA_W  engine result; valid one cycle after address
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_data  out  DATA_W  result word, signed, passed unmodified
- m_last  out  1  high on word OUT_WORDS-1 of each batch
- m_batch  out  $clog2(NUM_BATCHES)  batch index of m_data

## Operation

- States: IDLE, LAUNCH, WAIT, READ, NEXT.
- IDLE -> LAUNCH on cmd_start. Batch counter is cleared and cmd_error is cleared.
- LAUNCH lasts one cycle with eng_start=1, then -> WAIT. The armed flag is cleared.
- WAIT:
  - armed sets when eng_done is sampled low. This rejects a stale done left high from the previous batch.
  - eng_done=1 with armed=1 -> READ. Address counter is cleared.
- READ issues addresses into a 4-entry output FIFO under credit control.
  - A new address issues when (fifo_count + inflight) < 4 and addr_cnt < OUT_WORDS.
  - Data returned one cycle later is written to the FIFO, tagged with last = (addr == OUT_WORDS-1).
- READ -> NEXT when the beat with m_last is accepted (m_valid & m_ready).
- NEXT lasts one cycle:
  - If batch < NUM_BATCHES-1: increment batch, -> LAUNCH.
  - Else: pulse cmd_done, -> IDLE.
- cmd_abort in any state:
  - -> IDLE on the next edge.
  - FIFO and in-flight read are discarded; m_valid drops.
  - No cmd_done pulse; cmd_error unchanged.
- cmd_start while busy is ignored. cmd_abort and cmd_start in the same IDLE cycle: abort wins, stay IDLE.
- m_data is presented exactly as read; no saturation or sign change.
- Counters:
  - Address counter width is ADDR_W.
  - Batch counter never wraps past NUM_BATCHES-1.

## Timing

- Reset values: state IDLE; every output 0 (cmd_busy, cmd_done, cmd_error, eng_start, eng_read_addr, m_valid, m_data, m_last, m_batch); FIFO empty.
- cmd_start in cycle t (IDLE) -> eng_start=1 and cmd_busy=1 in cycle t+1.
- Launch latency: eng_done armed and seen high in cycle w -> first eng_read_addr=0 in cycle w+1 -> first m_valid in cycle w+3.
- With m_ready held at 1, throughput is one word per cycle, no bubbles.
- Per-batch drain: OUT_WORDS+2 cycles from READ entry to the last beat.
- Gap between batches: NEXT (1) + LAUNCH (1) + engine time.
- m_valid/m_data/m_last/m_batch hold stable while m_valid & !m_ready.
- cmd_done is asserted in the NEXT cycle of the final batch; cmd_busy falls the next cycle.
- rst mid-operation: immediate return to reset values. No eng_start is glitched.

## Configuration

- MAXPOOL_SEQ_TIMEOUT_EN defined:
  - WAIT runs a cycle counter, cleared on entry to WAIT.
  - Reaching TIMEOUT_CYCLES sets cmd_error, pulses cmd_done, -> IDLE.
- Not defined:
  - No counter; WAIT waits indefinitely.
  - cmd_error is tied 0.

## Test plan

- Full run, NUM_BATCHES=2, OUT_WORDS=8, engine model done 20 cycles after start, m_ready=1 -> exactly 2 eng_start pulses and 16 beats. m_last on beats 7 and 15, m_batch 0 then 1. Single cmd_done; data matches model, including signed -8 and 7.
- Backpressure: m_ready toggled pseudo-randomly -> no lost or duplicated words, payload stable while stalled. Never more than 4 words outstanding (FIFO plus in-flight).
- Stale done: engine holds eng_done=1 across the next eng_start for 5 cycles -> no READ until done drops and re-rises.
- Abort during READ at word 3 -> m_valid=0 next cycle, cmd_busy=0, no cmd_done. A following cmd_start restarts at batch 0, address 0.
- Timeout (macro on, TIMEOUT_CYCLES=50, engine never done) -> cmd_done pulse and cmd_error=1 at cycle 50 of WAIT. cmd_error clears on the next cmd_start.
- Async rst asserted mid-READ -> all outputs 0 within the same cycle, state IDLE.
